// File: rtl/access_authorizer_pkg.sv
// Shared types and constants for the access authorizer.
// Holds the FSM state encoding, default code table and counter sizing.
package auth_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_GRANT_M,
        S_WAIT_PORTER,
        S_GRANT_V,
        S_LOCKED
    } auth_state_t;

    // Entry i sits at bits [i*4 +: 4] of this packed table.
    localparam logic [15:0] DEF_CODES = {4'h3, 4'h5, 4'hA, 4'hC};

    // Width of the shared cycle counter: it must reach the longest limit - 1.
    function automatic int cnt_width(int a, int b, int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/access_authorizer_if.sv
// Keypad, intercom, porter and gate-side signals of the authorizer.
// The environment drives through master; the authorizer sits on slave.
interface access_authorizer_if #(
    parameter int NCODE_BITS = 4
);
    logic [NCODE_BITS-1:0] code_in;
    logic                  code_valid;
    logic                  visit_req;
    logic                  porter_ok;
    logic                  porter_deny;
    logic                  entrando_morador;
    logic                  entrando_visitante;
    logic                  chega_morador;
    logic                  chega_visitante;
    logic                  waiting_porter;
    logic                  lockout;
    logic [1:0]            fail_count;

    modport master (
        output code_in, code_valid, visit_req, porter_ok, porter_deny,
        output entrando_morador, entrando_visitante,
        input  chega_morador, chega_visitante, waiting_porter,
        input  lockout, fail_count
    );

    modport slave (
        input  code_in, code_valid, visit_req, porter_ok, porter_deny,
        input  entrando_morador, entrando_visitante,
        output chega_morador, chega_visitante, waiting_porter,
        output lockout, fail_count
    );
endinterface

// File: rtl/access_authorizer_code_matcher.sv
// Combinational lookup of a keypad code in the resident code table.
// Match is the OR of one equality compare per table entry.
module code_matcher #(
    parameter int NCODE_BITS = 4,
    parameter int NCODES     = 4
) (
    input  logic [NCODE_BITS-1:0]        code_i,
    input  logic [NCODES*NCODE_BITS-1:0] table_i,
    output logic                         match_o
);

    // OR-reduce the per-entry equality compares.
    always_comb begin
        match_o = 1'b0;
        for (int i = 0; i < NCODES; i++) begin
            if (table_i[i*NCODE_BITS +: NCODE_BITS] == code_i) begin
                match_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/access_authorizer.sv
// Turns keypad codes and intercom requests into gate arrival grants.
// Handles porter approval, grant hold time and keypad lockout.
module access_authorizer
    import auth_pkg::*;
#(
    parameter int                            NCODE_BITS     = 4,
    parameter int                            NCODES         = 4,
    parameter logic [NCODES*NCODE_BITS-1:0]  RESIDENT_CODES = DEF_CODES,
    parameter int                            MAX_TRIES      = 3,
    parameter int                            LOCK_CYCLES    = 16,
    parameter int                            GRANT_CYCLES   = 8,
    parameter int                            WAIT_CYCLES    = 32
) (
    input  logic                 clk_2,
    input  logic                 reset,
    access_authorizer_if.slave   bus
);

    localparam int CW = cnt_width(LOCK_CYCLES, WAIT_CYCLES, GRANT_CYCLES);
    localparam logic [CW-1:0] G_LAST = CW'(GRANT_CYCLES - 1);
    localparam logic [CW-1:0] W_LAST = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] L_LAST = CW'(LOCK_CYCLES - 1);
    localparam logic [1:0]    MAX_F  = 2'(MAX_TRIES);

    auth_state_t           state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            fail_q, fail_d;
    logic [NCODE_BITS-1:0] code_q, code_d;
    logic                  cv_prev_q, vr_prev_q;
    logic                  code_rise, visit_rise, match;

    assign code_rise  = bus.code_valid & ~cv_prev_q;
    assign visit_rise = bus.visit_req & ~vr_prev_q;

    code_matcher #(
        .NCODE_BITS (NCODE_BITS),
        .NCODES     (NCODES)
    ) u_match (
        .code_i  (code_q),
        .table_i (RESIDENT_CODES),
        .match_o (match)
    );

    // State, counter, failure count, code latch and edge-detect registers.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            fail_q    <= '0;
            code_q    <= '0;
            cv_prev_q <= 1'b0;
            vr_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fail_q    <= fail_d;
            code_q    <= code_d;
            cv_prev_q <= bus.code_valid;
            vr_prev_q <= bus.visit_req;
        end
    end

    // Next-state logic; resident edge beats visitor edge, deny beats ok.
    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        code_d  = code_q;
        unique case (state_q)
            S_IDLE: begin
                if (code_rise) begin
                    code_d  = bus.code_in;
                    state_d = S_CHECK;
                end else if (visit_rise) begin
                    state_d = S_WAIT_PORTER;
                end
            end
            S_CHECK: begin
                if (match) begin
                    fail_d  = '0;
                    state_d = S_GRANT_M;
                end else if (fail_q + 2'd1 == MAX_F) begin
                    fail_d  = MAX_F;
                    state_d = S_LOCKED;
                end else begin
                    fail_d  = fail_q + 2'd1;
                    state_d = S_IDLE;
                end
            end
            S_GRANT_M: begin
                if (bus.entrando_morador || cnt_q == G_LAST) state_d = S_IDLE;
            end
            S_WAIT_PORTER: begin
                if (bus.porter_deny || cnt_q == W_LAST) state_d = S_IDLE;
                else if (bus.porter_ok)                 state_d = S_GRANT_V;
            end
            S_GRANT_V: begin
                if (bus.entrando_visitante || cnt_q == G_LAST) state_d = S_IDLE;
            end
            S_LOCKED: begin
                if (cnt_q == L_LAST) begin
                    fail_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Shared counter restarts on every state entry and rests at 0 in idle.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;
    end

    assign bus.chega_morador   = (state_q == S_GRANT_M);
    assign bus.chega_visitante = (state_q == S_GRANT_V);
    assign bus.waiting_porter  = (state_q == S_WAIT_PORTER);
    assign bus.lockout         = (state_q == S_LOCKED);
    assign bus.fail_count      = fail_q;

endmodule

// File: tb/tb_access_authorizer.sv
// Randomized scenario bench for access_authorizer.
// Expected output waveforms are computed from timing rules per scenario.
module tb_access_authorizer;

    logic clk_2 = 1'b0;
    logic reset;

    always #5 clk_2 = ~clk_2;

    access_authorizer_if #(.NCODE_BITS(4)) bus ();

    access_authorizer dut (
        .clk_2 (clk_2),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    localparam logic [15:0] TABLE = {4'h3, 4'h5, 4'hA, 4'hC};

    function automatic bit is_valid(logic [3:0] c);
        for (int i = 0; i < 4; i++)
            if (TABLE[i*4 +: 4] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] rand_code(bit want_valid);
        logic [3:0] c;
        c = 4'(($urandom_range(0, 15)));
        while (is_valid(c) != want_valid) c = 4'(($urandom_range(0, 15)));
        return c;
    endfunction

    // {chega_morador, chega_visitante, waiting_porter, lockout, fail_count}
    function automatic logic [5:0] obs();
        return {bus.chega_morador, bus.chega_visitante, bus.waiting_porter,
                bus.lockout, bus.fail_count};
    endfunction

    function automatic logic [5:0] mk(bit cm, bit cv, bit wp, bit lo, int fc);
        return {cm, cv, wp, lo, 2'(fc)};
    endfunction

    task automatic step();
        @(posedge clk_2);
        #1;
    endtask

    task automatic clear_inputs();
        bus.code_in            = 4'h0;
        bus.code_valid         = 1'b0;
        bus.visit_req          = 1'b0;
        bus.porter_ok          = 1'b0;
        bus.porter_deny        = 1'b0;
        bus.entrando_morador   = 1'b0;
        bus.entrando_visitante = 1'b0;
    endtask

    task automatic idle(int n);
        clear_inputs();
        repeat (n) step();
    endtask

    task automatic test_reset();
        logic [5:0] e;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.code_in            = 4'(($urandom_range(0, 15)));
            bus.code_valid         = 1'($urandom_range(0, 1));
            bus.visit_req          = 1'($urandom_range(0, 1));
            bus.porter_ok          = 1'($urandom_range(0, 1));
            bus.porter_deny        = 1'($urandom_range(0, 1));
            bus.entrando_morador   = 1'($urandom_range(0, 1));
            bus.entrando_visitante = 1'($urandom_range(0, 1));
            step();
            e = mk(0, 0, 0, 0, 0);
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL reset c=%0d got=%b exp=%b", c, obs(), e);
            end
        end
        clear_inputs();
        step();
        reset = 1'b0;
        step();
        e = mk(0, 0, 0, 0, 0);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL reset_release got=%b exp=%b", obs(), e);
        end
    endtask

    // Valid code, code_valid held high, sensor pulse in grant cycle r.
    task automatic test_resident(int r);
        int len;
        logic [5:0] e;
        len = (r < 8) ? r + 1 : 8;
        bus.code_in    = rand_code(1'b1);
        bus.code_valid = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            step();
            e = mk(c >= 2 && c < 2 + len, 0, 0, 0, 0);
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL resident r=%0d c=%0d got=%b exp=%b",
                         r, c, obs(), e);
            end
            bus.entrando_morador = (c == 2 + r);
        end
        idle(3);
    endtask

    task automatic test_lockout();
        int k;
        logic [5:0] e;
        for (int a = 1; a <= 3; a++) begin
            bus.code_in    = rand_code(1'b0);
            bus.code_valid = 1'b1;
            step();
            bus.code_valid = 1'b0;
            step();
            e = (a < 3) ? mk(0, 0, 0, 0, a) : mk(0, 0, 0, 1, 3);
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL lock_attempt a=%0d got=%b exp=%b", a, obs(), e);
            end
        end
        k = $urandom_range(3, 12);
        for (int c = 3; c <= 20; c++) begin
            if (c == k) begin
                bus.code_in    = 4'h3;
                bus.code_valid = 1'b1;
            end
            if (c == k + 1) bus.visit_req = 1'b1;
            step();
            e = (c <= 17) ? mk(0, 0, 0, 1, 3) : mk(0, 0, 0, 0, 0);
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL lock_hold c=%0d got=%b exp=%b", c, obs(), e);
            end
        end
        idle(1);
        bus.code_in    = 4'h3;
        bus.code_valid = 1'b1;
        step();
        step();
        e = mk(1, 0, 0, 0, 0);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL lock_after_grant got=%b exp=%b", obs(), e);
        end
        idle(10);
    endtask

    // Porter approves after d waiting cycles; sensor pulse in grant cycle r.
    task automatic test_visitor(int d, int r);
        int len;
        logic [5:0] e;
        len = (r < 8) ? r + 1 : 8;
        bus.visit_req = 1'b1;
        for (int c = 1; c <= d + 12; c++) begin
            step();
            e = mk(0, c > d && c <= d + len, c <= d, 0, 0);
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL visitor d=%0d r=%0d c=%0d got=%b exp=%b",
                         d, r, c, obs(), e);
            end
            bus.porter_ok          = (c == d);
            bus.entrando_visitante = (c == d + 1 + r);
        end
        idle(3);
    endtask

    // Deny-with-ok after d cycles, or no porter answer at all.
    task automatic test_reject(bit timeout, int d);
        int n;
        logic [5:0] e;
        n = timeout ? 36 : d + 6;
        bus.visit_req = 1'b1;
        for (int c = 1; c <= n; c++) begin
            step();
            e = mk(0, 0, timeout ? (c <= 32) : (c <= d), 0, 0);
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL reject to=%0d d=%0d c=%0d got=%b exp=%b",
                         timeout, d, c, obs(), e);
            end
            bus.porter_ok   = !timeout && (c == d);
            bus.porter_deny = !timeout && (c == d);
            bus.code_in     = rand_code(1'b1);
            bus.code_valid  = (c == 1);
        end
        idle(3);
    endtask

    task automatic test_priority();
        logic [5:0] e;
        bus.code_in    = 4'hA;
        bus.code_valid = 1'b1;
        bus.visit_req  = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            e = mk(c >= 2 && c < 10, 0, 0, 0, 0);
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL priority c=%0d got=%b exp=%b", c, obs(), e);
            end
        end
        idle(3);
    endtask

    task automatic test_reset_mid();
        int k;
        logic [5:0] e;
        k = $urandom_range(2, 8);
        bus.code_in    = rand_code(1'b1);
        bus.code_valid = 1'b1;
        repeat (k) step();
        e = mk(1, 0, 0, 0, 0);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL reset_mid_pre got=%b exp=%b", obs(), e);
        end
        reset = 1'b1;
        step();
        e = mk(0, 0, 0, 0, 0);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL reset_mid got=%b exp=%b", obs(), e);
        end
        clear_inputs();
        step();
        reset = 1'b0;
        idle(3);
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_resident(3);
        test_resident(10);
        repeat (4) test_resident($urandom_range(0, 9));
        test_lockout();
        test_visitor(5, 9);
        repeat (3) test_visitor($urandom_range(1, 20), $urandom_range(0, 9));
        test_reject(1'b0, $urandom_range(3, 15));
        test_reject(1'b1, 0);
        test_priority();
        test_reset_mid();
        test_resident($urandom_range(0, 9));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
